// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared definitions for the sync FIFO pointer/handshake controller:
// default depth and controller state encoding.
package fifo_ptr_ctrl_pkg;

    localparam int unsigned CFG_FIFO_DEPTH = 8;

    typedef enum logic {
        FPC_RUN   = 1'b0,
        FPC_FLUSH = 1'b1
    } fpc_state_e;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Extended (wrap-bit) FIFO pointer: increments modulo 2^WIDTH, with a
// synchronous clear that takes priority over increment.
module fifo_ptr_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Sync FIFO pointer and handshake controller: qualifies write/read accepts,
// drives RAM enables/addresses, and tracks read latency, flush and errors.
module fifo_ptr_ctrl
    import fifo_ptr_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = CFG_FIFO_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_valid_s,
    input  logic                  i_ready_s,
    input  logic                  i_ready_m,
    input  logic                  i_valid_m,
    input  logic                  i_flush,
    input  logic                  i_err_clr,
    output logic [ADDR_WIDTH:0]   wr_addr,
    output logic [ADDR_WIDTH:0]   rd_addr,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_waddr,
    output logic                  o_mem_re,
    output logic [ADDR_WIDTH-1:0] o_mem_raddr,
    output logic                  o_rdata_valid,
    output logic                  o_flushing,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    fpc_state_e state_q;
    fpc_state_e state_d;
    logic       run_ok;
    logic       wr_acc;
    logic       rd_acc;
    logic       ovf_set;
    logic       unf_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FPC_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        o_flushing = 1'b0;
        unique case (state_q)
            FPC_RUN: begin
                if (i_flush) state_d = FPC_FLUSH;
            end
            FPC_FLUSH: begin
                o_flushing = 1'b1;
                state_d    = i_flush ? FPC_FLUSH : FPC_RUN;
            end
            default: state_d = FPC_RUN;
        endcase
    end

    // Nothing is accepted or flagged outside RUN or while a flush is requested.
    assign run_ok  = (state_q == FPC_RUN) && !i_flush;
    assign wr_acc  = i_valid_s && i_ready_s && run_ok;
    assign rd_acc  = i_ready_m && i_valid_m && run_ok;
    assign ovf_set = i_valid_s && !i_ready_s && run_ok;
    assign unf_set = i_ready_m && !i_valid_m && run_ok;

    fifo_ptr_cnt #(.WIDTH(ADDR_WIDTH + 1)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (i_flush),
        .inc     (wr_acc),
        .cnt     (wr_addr)
    );

    fifo_ptr_cnt #(.WIDTH(ADDR_WIDTH + 1)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (i_flush),
        .inc     (rd_acc),
        .cnt     (rd_addr)
    );

    assign o_mem_we    = wr_acc;
    assign o_mem_re    = rd_acc;
    assign o_mem_waddr = wr_addr[ADDR_WIDTH-1:0];
    assign o_mem_raddr = rd_addr[ADDR_WIDTH-1:0];

    // A new violation wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_rdata_valid <= 1'b0;
            o_overflow    <= 1'b0;
            o_underflow   <= 1'b0;
        end else begin
            o_rdata_valid <= rd_acc;
            o_overflow    <= ovf_set || (o_overflow && !i_err_clr);
            o_underflow   <= unf_set || (o_underflow && !i_err_clr);
        end
    end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed-vector bench for fifo_ptr_ctrl at FIFO_DEPTH=8 (ADDR_WIDTH=3).
module tb_fifo_ptr_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_valid_s, i_ready_s, i_ready_m, i_valid_m, i_flush, i_err_clr;
    logic [3:0] wr_addr, rd_addr;
    logic       o_mem_we, o_mem_re;
    logic [2:0] o_mem_waddr, o_mem_raddr;
    logic       o_rdata_valid, o_flushing, o_overflow, o_underflow;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    fifo_ptr_ctrl #(.FIFO_DEPTH(8), .ADDR_WIDTH(3)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_valid_s     (i_valid_s),
        .i_ready_s     (i_ready_s),
        .i_ready_m     (i_ready_m),
        .i_valid_m     (i_valid_m),
        .i_flush       (i_flush),
        .i_err_clr     (i_err_clr),
        .wr_addr       (wr_addr),
        .rd_addr       (rd_addr),
        .o_mem_we      (o_mem_we),
        .o_mem_waddr   (o_mem_waddr),
        .o_mem_re      (o_mem_re),
        .o_mem_raddr   (o_mem_raddr),
        .o_rdata_valid (o_rdata_valid),
        .o_flushing    (o_flushing),
        .o_overflow    (o_overflow),
        .o_underflow   (o_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vs, input logic rs, input logic rm, input logic vm,
                         input logic fl, input logic ec);
        i_valid_s = vs; i_ready_s = rs; i_ready_m = rm; i_valid_m = vm;
        i_flush = fl; i_err_clr = ec;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_rvalid", 32'(o_rdata_valid), 0);
        check("rst_flushing", 32'(o_flushing), 0);
        check("rst_ovf", 32'(o_overflow), 0);
        check("rst_unf", 32'(o_underflow), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // 16 writes: address walks 0..7 twice, MSB toggles after 8
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            check("wr_we", 32'(o_mem_we), 1);
            check("wr_waddr", 32'(o_mem_waddr), 32'(i % 8));
            tick();
            if (i == 7) begin
                check("wr_addr_8", 32'(wr_addr), 32'h8);
                check("waddr_after_8", 32'(o_mem_waddr), 0);
            end
        end
        check("wr_addr_16", 32'(wr_addr), 0);

        // set up wr=5, rd=2
        drive(1, 1, 1, 1, 0, 0); tick(); tick();
        drive(1, 1, 0, 0, 0, 0); tick(); tick(); tick();
        drive(0, 0, 0, 0, 0, 0);
        check("setup_wr", 32'(wr_addr), 5);
        check("setup_rd", 32'(rd_addr), 2);

        drive(1, 1, 1, 1, 0, 0);
        check("sim_we", 32'(o_mem_we), 1);
        check("sim_re", 32'(o_mem_re), 1);
        check("sim_waddr", 32'(o_mem_waddr), 5);
        check("sim_raddr", 32'(o_mem_raddr), 2);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("sim_wr", 32'(wr_addr), 6);
        check("sim_rd", 32'(rd_addr), 3);
        tick();
        check("rv_idle", 32'(o_rdata_valid), 0);

        // single read at rd_addr=3
        drive(0, 0, 1, 1, 0, 0);
        check("lat_re", 32'(o_mem_re), 1);
        check("lat_raddr", 32'(o_mem_raddr), 3);
        check("lat_rv_N", 32'(o_rdata_valid), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("lat_rv_N1", 32'(o_rdata_valid), 1);
        check("lat_rd", 32'(rd_addr), 4);
        tick();
        check("lat_rv_N2", 32'(o_rdata_valid), 0);

        // overflow and clear
        drive(1, 0, 0, 0, 0, 0);
        check("ovf_we", 32'(o_mem_we), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("ovf_set", 32'(o_overflow), 1);
        check("ovf_wr", 32'(wr_addr), 6);
        tick();
        check("ovf_hold", 32'(o_overflow), 1);
        drive(0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0);
        check("ovf_clr", 32'(o_overflow), 0);
        drive(1, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0);
        check("ovf_set_wins", 32'(o_overflow), 1);
        drive(0, 0, 1, 0, 0, 0);
        check("unf_re", 32'(o_mem_re), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("unf_set", 32'(o_underflow), 1);
        check("unf_rd", 32'(rd_addr), 4);

        // reach wr=9, rd=4 then flush
        drive(1, 1, 0, 0, 0, 0); tick(); tick(); tick();
        check("pre_fl_wr", 32'(wr_addr), 9);
        drive(1, 1, 1, 1, 1, 0);
        check("fl_we", 32'(o_mem_we), 0);
        check("fl_re", 32'(o_mem_re), 0);
        check("fl_flushing0", 32'(o_flushing), 0);
        tick();
        drive(1, 0, 1, 0, 0, 0);
        check("fl_wr0", 32'(wr_addr), 0);
        check("fl_rd0", 32'(rd_addr), 0);
        check("fl_flushing1", 32'(o_flushing), 1);
        check("fl_rv", 32'(o_rdata_valid), 0);
        check("fls_we", 32'(o_mem_we), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("fl_flushing_end", 32'(o_flushing), 0);
        check("fl_ovf_kept", 32'(o_overflow), 1);
        check("fl_unf_kept", 32'(o_underflow), 1);
        check("fl_wr_still0", 32'(wr_addr), 0);

        // held flush stays in FLUSH
        drive(0, 0, 0, 0, 1, 0); tick(); tick();
        check("fl_held", 32'(o_flushing), 1);
        drive(0, 0, 0, 0, 0, 0); tick();
        check("fl_held_exit", 32'(o_flushing), 0);

        // async reset during a read-accept cycle
        drive(1, 1, 0, 0, 0, 0); tick(); tick();
        drive(0, 0, 1, 1, 0, 0);
        check("ar_re", 32'(o_mem_re), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_wr", 32'(wr_addr), 0);
        check("ar_rd", 32'(rd_addr), 0);
        check("ar_ovf", 32'(o_overflow), 0);
        check("ar_unf", 32'(o_underflow), 0);
        tick();
        check("ar_rv", 32'(o_rdata_valid), 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("ar_post_rv", 32'(o_rdata_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
